// File: rtl/pwm_capture_pkg.sv
// pwm_capture_pkg
// Shared constants for the PWM capture monitor: the Avalon-MM register map
// and the bit positions inside the STATUS register.
// No ports; imported by pwm_capture_monitor.
package pwm_capture_pkg;

    // Register map, word addresses on the Avalon slave.
    localparam logic [1:0] REG_PERIOD = 2'd0;
    localparam logic [1:0] REG_HIGH_A = 2'd1;
    localparam logic [1:0] REG_HIGH_B = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    // STATUS bit positions.
    localparam int ST_VALID   = 0;
    localparam int ST_FAULT   = 1;
    localparam int ST_TIMEOUT = 2;

endpackage

// File: rtl/pwm_edge_sync.sv
// pwm_edge_sync
// Brings one asynchronous PWM leg into the clk domain and flags its rising
// edge.
//   clk    in   system clock
//   reset  in   synchronous, active-high reset
//   pwm    in   raw leg signal, asynchronous to clk
//   level  out  synchronized level, SYNC_STAGES cycles after the pin
//   rise   out  one-cycle pulse, one cycle after level goes high
module pwm_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic pwm,
    output logic level,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Shift the pin through the synchronizer chain, keep one more copy of
    // the synchronized level and register the rising-edge comparison so the
    // pulse lands one cycle after the level.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm};
            prev_q <= sync_q[SYNC_STAGES-1];
            rise   <= sync_q[SYNC_STAGES-1] & ~prev_q;
        end
    end

    assign level = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pwm_capture_monitor.sv
// pwm_capture_monitor
// Measures the period of leg A and the high time of both legs, latches a
// shoot-through fault when both legs are high together and a timeout when
// leg A stops toggling. Results are read over an Avalon-MM slave.
//   clk            in   system clock
//   reset          in   synchronous, active-high reset
//   pwm_a, pwm_b   in   complementary PWM legs, asynchronous to clk
//   avs_address    in   register select (PERIOD, HIGH_A, HIGH_B, STATUS)
//   avs_read       in   read strobe, data returned one cycle later
//   avs_readdata   out  read data, counters zero-extended to 32 bits
//   avs_write      in   write strobe, only STATUS (W1C flags) is writable
//   avs_writedata  in   write data
//   irq            out  level interrupt, mirrors the fault flag
//   pwm_fault      out  shoot-through fault, mirrors the fault flag
module pwm_capture_monitor
    import pwm_capture_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pwm_a,
    input  logic        pwm_b,
    input  logic [1:0]  avs_address,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic        irq,
    output logic        pwm_fault
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic a_s, a_rise;
    logic b_s, b_rise;

    logic [CNT_W-1:0] per_cnt, hi_a_cnt, hi_b_cnt;
    logic [CNT_W-1:0] period_reg, high_a_reg, high_b_reg;
    logic             armed, valid, fault, timeout;

    logic        status_wr, fault_set, fault_clr, timeout_set, timeout_clr;
    logic [31:0] status_word;
    logic        unused_bits;

    pwm_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_a (
        .clk   (clk),
        .reset (reset),
        .pwm   (pwm_a),
        .level (a_s),
        .rise  (a_rise)
    );

    pwm_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_b (
        .clk   (clk),
        .reset (reset),
        .pwm   (pwm_b),
        .level (b_s),
        .rise  (b_rise)
    );

    // Leg B's edge pulse and the non-flag write bits have no use here.
    assign unused_bits = &{1'b0, b_rise, avs_writedata[31:3], avs_writedata[0]};

    // Free-running measurement counters. A rise of leg A restarts them; the
    // restart values already include the rise cycle itself, because a_s has
    // been high one cycle before a_rise pulses. Counters saturate, never wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            per_cnt  <= '0;
            hi_a_cnt <= '0;
            hi_b_cnt <= '0;
        end else if (a_rise) begin
            per_cnt  <= CNT_ONE;
            hi_a_cnt <= CNT_ONE;
            hi_b_cnt <= CNT_W'(b_s);
        end else begin
            if (per_cnt != CNT_MAX) begin
                per_cnt <= per_cnt + CNT_ONE;
            end
            if (a_s && (hi_a_cnt != CNT_MAX)) begin
                hi_a_cnt <= hi_a_cnt + CNT_ONE;
            end
            if (b_s && (hi_b_cnt != CNT_MAX)) begin
                hi_b_cnt <= hi_b_cnt + CNT_ONE;
            end
        end
    end

    // Snapshot on every rise except the first one after reset, whose
    // counters cover only a partial period.
    always_ff @(posedge clk) begin
        if (reset) begin
            armed      <= 1'b0;
            valid      <= 1'b0;
            period_reg <= '0;
            high_a_reg <= '0;
            high_b_reg <= '0;
        end else if (a_rise) begin
            armed <= 1'b1;
            if (armed) begin
                valid      <= 1'b1;
                period_reg <= per_cnt;
                high_a_reg <= hi_a_cnt;
                high_b_reg <= hi_b_cnt;
            end
        end
    end

    // Sticky flag set and write-one-to-clear terms.
    always_comb begin
        status_wr   = avs_write && (avs_address == REG_STATUS);
        fault_set   = a_s & b_s;
        timeout_set = (per_cnt == CNT_MAX);
        fault_clr   = status_wr & avs_writedata[ST_FAULT];
        timeout_clr = status_wr & avs_writedata[ST_TIMEOUT];
    end

    // Sticky flags; a set event in the same cycle as a clear keeps the flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            fault   <= 1'b0;
            timeout <= 1'b0;
        end else begin
            fault   <= fault_set   | (fault   & ~fault_clr);
            timeout <= timeout_set | (timeout & ~timeout_clr);
        end
    end

    always_comb begin
        status_word              = '0;
        status_word[ST_VALID]    = valid;
        status_word[ST_FAULT]    = fault;
        status_word[ST_TIMEOUT]  = timeout;
    end

    // Read data is captured from the registers as they stand in the read
    // cycle, so a snapshot or W1C landing on that same edge shows up only on
    // the following read.
    always_ff @(posedge clk) begin
        if (reset) begin
            avs_readdata <= '0;
        end else if (avs_read) begin
            case (avs_address)
                REG_PERIOD: avs_readdata <= 32'(period_reg);
                REG_HIGH_A: avs_readdata <= 32'(high_a_reg);
                REG_HIGH_B: avs_readdata <= 32'(high_b_reg);
                default:    avs_readdata <= status_word;
            endcase
        end
    end

    assign irq       = fault;
    assign pwm_fault = fault;

endmodule
